dff_ram_dp: RTL and testbench
=============================

// Module: dff_ram_dp
// PURPOSE
//  Parametrised simple-dual-port RAM built from flip-flops: one write port, one read port, both on clk.
//  Next-generation flop RAM: parametrised width and depth, byte write enables,
//  selectable read latency with valid strobe, defined read-during-write, array clear.
//  Used as a small register-file/buffer store inside datapath blocks.
// PARAMETERS
//  DATA_W    72  word width in bits; must be a multiple of 8
//  ADDR_W    2   address width; DEPTH = 2**ADDR_W words
//  READ_LAT  1   read latency in cycles, 1 or 2 (2 adds an output register stage)
//  WR_FIRST  1   same-address read/write in one cycle: 1 = return new data, 0 = return old data
// PORTS
//  clk       in   1         clock, all logic on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  clr       in   1         synchronous clear of the whole array
//  wr_en     in   1         write request
//  wr_addr   in   ADDR_W    write address
//  wr_data   in   DATA_W    write data
//  wr_be     in   DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
//  rd_en     in   1         read request
//  rd_addr   in   ADDR_W    read address
//  rd_data   out  DATA_W    read data, held until next valid read
//  rd_valid  out  1         1-cycle strobe: rd_data holds the result of a read
// BEHAVIOUR
//  Reset (rst_n=0, async): all DEPTH words <= 0, rd_data <= 0, rd_valid <= 0, pipeline stages <= 0.
//  Write: at edge with wr_en=1 and clr=0, each byte i with wr_be[i]=1 is updated; other bytes keep their value.
//   wr_en=1 with wr_be=0 is a legal no-op.
//  Read: rd_en=1 sampled at edge N.
//   READ_LAT=1: rd_data and rd_valid=1 are valid after edge N.
//   READ_LAT=2: rd_data and rd_valid=1 are valid after edge N+1.
//   Back-to-back reads: one result per cycle, in order.
//   rd_valid is 0 in every cycle with no completing read; rd_data is not updated in those cycles.
//  Read-during-write (rd_en & wr_en & rd_addr==wr_addr, same edge):
//   WR_FIRST=1: returned word = old word with the enabled bytes replaced by wr_data (byte-merged bypass).
//   WR_FIRST=0: returned word = old word, before the write.
//  clr: at edge with clr=1, all words <= 0.
//   A write in the same cycle is dropped (clr wins).
//   A read in the same cycle still completes and returns pre-clear contents; WR_FIRST bypass does not apply.
//   Reads in flight at READ_LAT=2 complete normally.
//  Address range: ADDR_W covers DEPTH exactly, so out-of-range addresses cannot occur. No wrap logic.
//  Reset asserted mid-read: the pending read is discarded; no rd_valid is produced for it after release.
//  No X propagation: the array is always reset-initialised.
// TESTING
//  1. Reset, then read all 4 addrs (DATA_W=72, ADDR_W=2) -> rd_data=0, rd_valid=1 for 4 consecutive cycles.
//  2. Write addr1=72'hAB_0123456789ABCDEF with wr_be=9'h1FF, then write addr1 data=72'hFF..FF, wr_be=9'h001
//     -> read addr1 returns 72'hAB_0123456789ABCDFF.
//  3. Same-cycle write addr2=72'h5A.. and read addr2, old word 0:
//     WR_FIRST=1 -> 72'h5A.., WR_FIRST=0 -> 0.
//  4. READ_LAT=2: reads to addr0..3 on consecutive cycles -> rd_valid high 2 cycles after the first rd_en,
//     4 cycles wide, data in order.
//  5. Fill all addrs; clr=1 with wr_en=1 (addr3) and rd_en=1 (addr0)
//     -> read returns the old addr0 value; all later reads return 0, including addr3.
//  6. rst_n pulsed low for 1 cycle between rd_en and the READ_LAT=2 result
//     -> rd_valid stays 0, rd_data=0, and the array reads back all zeros.

Source files
------------

// File: rtl/dff_ram_dp.sv
// dff_ram_dp: flop-based simple-dual-port RAM with byte enables, 1/2-cycle read latency and array clear.
module dff_ram_dp #(
  parameter int DATA_W   = 72,
  parameter int ADDR_W   = 2,
  parameter int READ_LAT = 1,
  parameter int WR_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_word, s1_data_q, s1_data_d, rd_data_q, rd_data_d;
  logic              s1_valid_q, s1_valid_d, rd_valid_q, rd_valid_d;
  always_comb begin
    mem_d = mem_q;
    if (clr)
      for (int a = 0; a < DEPTH; a++) mem_d[a] = '0;
    else if (wr_en)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) mem_d[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
    // mem_d already holds the byte-merged word, so it doubles as the write-first bypass
    rd_word    = (WR_FIRST != 0 && !clr) ? mem_d[rd_addr] : mem_q[rd_addr];
    s1_valid_d = rd_en;
    s1_data_d  = rd_en ? rd_word : s1_data_q;
    rd_valid_d = (READ_LAT == 2) ? s1_valid_q : rd_en;
    rd_data_d  = rd_valid_d ? ((READ_LAT == 2) ? s1_data_q : rd_word) : rd_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_dff_ram_dp.sv
// tb_dff_ram_dp: four parameter variants driven in lockstep, checked against a queue-based reference model.
module tb_dff_ram_dp;
  logic        clk = 0, rst_n = 0, clr = 0, wr_en = 0, rd_en = 0;
  logic [1:0]  wr_addr = 0, rd_addr = 0;
  logic [71:0] wr_data = 0;
  logic [8:0]  wr_be = 0;
  logic [71:0] rd_data [4];
  logic        rd_valid [4];
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  // instance g: READ_LAT = 1 + g/2, WR_FIRST = g%2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dff_ram_dp #(.DATA_W(72), .ADDR_W(2), .READ_LAT(1 + g / 2), .WR_FIRST(g % 2)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data[g]), .rd_valid(rd_valid[g]));
  end
  typedef struct {int due; logic [71:0] d;} ent_t;
  ent_t        q [4][$];
  logic [71:0] mem [4];
  logic [71:0] exp_d [4];
  logic        exp_v [4];
  function automatic logic [71:0] merge(logic [71:0] o, logic [71:0] n, logic [8:0] be);
    logic [71:0] r = o;
    for (int b = 0; b < 9; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction
  task automatic chk(string n, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin : model
    ent_t e;
    if (!rst_n) begin
      for (int g = 0; g < 4; g++) begin
        q[g].delete();
        exp_d[g] = '0;
        exp_v[g] = 1'b0;
        mem[g] = '0;
      end
    end else begin
      cyc++;
      if (rd_en)
        for (int g = 0; g < 4; g++) begin
          e.due = cyc + g / 2;
          e.d = (g % 2 == 1 && wr_en && !clr && wr_addr == rd_addr) ?
                merge(mem[rd_addr], wr_data, wr_be) : mem[rd_addr];
          q[g].push_back(e);
        end
      if (clr) for (int a = 0; a < 4; a++) mem[a] = '0;
      else if (wr_en) mem[wr_addr] = merge(mem[wr_addr], wr_data, wr_be);
      for (int g = 0; g < 4; g++) begin
        exp_v[g] = 1'b0;
        if (q[g].size() > 0 && q[g][0].due == cyc) begin
          exp_v[g] = 1'b1;
          exp_d[g] = q[g][0].d;
          void'(q[g].pop_front());
        end
      end
    end
  end
  always @(negedge clk)
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("valid%0d@%0d", g, cyc), {71'd0, rd_valid[g]}, {71'd0, exp_v[g]});
      chk($sformatf("data%0d@%0d", g, cyc), rd_data[g], exp_d[g]);
    end
  task automatic drive(logic we, logic [1:0] wa, logic [71:0] wd, logic [8:0] be,
                       logic re, logic [1:0] ra, logic c);
    @(negedge clk); #1;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra; clr = c;
  endtask
  task automatic idle(int n);
    repeat (n) drive(0, 0, '0, '0, 0, 0, 0);
  endtask
  task automatic lit(string n, logic [71:0] e0, logic [71:0] e1);
    for (int g = 0; g < 4; g++) chk($sformatf("%s_%0d", n, g), rd_data[g], (g % 2) ? e1 : e0);
  endtask
  localparam logic [71:0] FILL [4] = '{72'h11_2233445566778899, 72'h22_0000000000000001,
                                       72'h33_FEDCBA9876543210, 72'h44_1111111111111111};
  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    for (int a = 0; a < 4; a++) drive(0, 0, '0, '0, 1, 2'(a), 0);
    idle(3);
    lit("t1_zero", '0, '0);
    drive(1, 1, 72'hAB_0123456789ABCDEF, 9'h1FF, 0, 0, 0);
    drive(1, 1, {72{1'b1}}, 9'h001, 0, 0, 0);
    drive(0, 0, '0, '0, 1, 1, 0);
    idle(3);
    lit("t2_be", 72'hAB_0123456789ABCDFF, 72'hAB_0123456789ABCDFF);
    drive(1, 2, 72'h5A5A5A5A5A5A5A5A5A, 9'h1FF, 1, 2, 0);
    idle(3);
    lit("t3_rdw", '0, 72'h5A5A5A5A5A5A5A5A5A);
    for (int a = 0; a < 4; a++) drive(1, 2'(a), FILL[a], 9'h1FF, 0, 0, 0);
    for (int a = 0; a < 4; a++) drive(0, 0, '0, '0, 1, 2'(a), 0);
    idle(3);
    lit("t4_last", FILL[3], FILL[3]);
    drive(1, 3, 72'hCC_CCCCCCCCCCCCCCCC, 9'h1FF, 1, 0, 1);
    idle(3);
    lit("t5_preclr", FILL[0], FILL[0]);
    for (int a = 0; a < 4; a++) drive(0, 0, '0, '0, 1, 2'(a), 0);
    idle(3);
    lit("t5_cleared", '0, '0);
    drive(1, 1, 72'h77_7777777777777777, 9'h1FF, 0, 0, 0);
    drive(0, 0, '0, '0, 1, 1, 0);
    @(negedge clk); #1;
    rd_en = 0;
    rst_n = 0;
    @(negedge clk); #1;
    rst_n = 1;
    idle(2);
    chk("t6_valid", {71'd0, rd_valid[2]}, 72'd0);
    lit("t6_data", '0, '0);
    for (int a = 0; a < 4; a++) drive(0, 0, '0, '0, 1, 2'(a), 0);
    idle(3);
    lit("t6_array", '0, '0);
    repeat (400)
      drive(1'($urandom), 2'($urandom), 72'({$urandom(), $urandom(), $urandom()}), 9'($urandom),
            1'($urandom), 2'($urandom), $urandom_range(0, 19) == 0);
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
